// File: rtl/mod_serial_comp.sv
// mod_serial_comp: bit-serial magnitude comparator.
// One accepted START captures two N-bit operands and the cascade inputs. The operands are
// then walked MSB-first, one bit per clock, and the walk stops at the first differing bit.
// If every bit matches, the captured cascade inputs are copied to GT/EQ/LT unchanged.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START               request, accepted only while BUSY=0
//   A, B                operands, sampled on accepted START
//   GT_IN, EQ_IN, LT_IN cascade from lower-order stage, sampled on accepted START
//   BUSY                high while comparing
//   DONE                one-cycle pulse, GT/EQ/LT/CYCLES valid
//   GT, EQ, LT          registered result, held until next accepted START
//   CYCLES              number of bits examined for the last result (1..N)
module mod_serial_comp #(
   parameter int unsigned N = 8,
   localparam int unsigned CW = $clog2(N + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [N-1:0]  A,
   input  logic [N-1:0]  B,
   input  logic          GT_IN,
   input  logic          EQ_IN,
   input  logic          LT_IN,
   output logic          BUSY,
   output logic          DONE,
   output logic          GT,
   output logic          EQ,
   output logic          LT,
   output logic [CW-1:0] CYCLES
);

   // Bit index width; at least one bit even when N=1.
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [2:0]    casc_q, casc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cycles_d;
   logic          busy_d, done_d, gt_d, eq_d, lt_d;
   logic          bit_a, bit_b;

   // State and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         casc_q  <= '0;
         idx_q   <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         GT      <= 1'b0;
         EQ      <= 1'b0;
         LT      <= 1'b0;
         CYCLES  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         casc_q  <= casc_d;
         idx_q   <= idx_d;
         BUSY    <= busy_d;
         DONE    <= done_d;
         GT      <= gt_d;
         EQ      <= eq_d;
         LT      <= lt_d;
         CYCLES  <= cycles_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      casc_d   = casc_q;
      idx_d    = idx_q;
      busy_d   = BUSY;
      done_d   = 1'b0;
      gt_d     = GT;
      eq_d     = EQ;
      lt_d     = LT;
      cycles_d = CYCLES;
      bit_a    = a_q[idx_q];
      bit_b    = b_q[idx_q];

      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d  = S_RUN;
               a_d      = A;
               b_d      = B;
               casc_d   = {GT_IN, EQ_IN, LT_IN};
               idx_d    = IW'(N - 1);
               busy_d   = 1'b1;
               gt_d     = 1'b0;
               eq_d     = 1'b0;
               lt_d     = 1'b0;
               cycles_d = '0;
            end
         end
         S_RUN: begin
            cycles_d = CYCLES + CW'(1);
            if (bit_a != bit_b) begin
               // First differing bit decides; the 1 side is the larger operand.
               gt_d    = bit_a;
               lt_d    = bit_b;
               eq_d    = 1'b0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (idx_q == '0) begin
               // All bits equal: cascade passed through literally, even if not one-hot.
               {gt_d, eq_d, lt_d} = casc_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mod_serial_comp.sv
// Testbench for mod_serial_comp: directed table, handshake corner sequences, randomized
// compares against an arithmetic reference model, plus a small N=1 instance.
module tb_mod_serial_comp;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = $clog2(N + 1);

   logic          clk, rst, start;
   logic [N-1:0]  a, b;
   logic          gi, ei, li;
   logic          busy, done, gt, eq, lt;
   logic [CW-1:0] cycles;

   logic          start1;
   logic [0:0]    a1, b1;
   logic          gi1, ei1, li1;
   logic          busy1, done1, gt1, eq1, lt1;
   logic [0:0]    cycles1;

   int checks   = 0;
   int failures = 0;

   mod_serial_comp #(.N(N)) u_dut (
      .CLK(clk), .RST(rst), .START(start), .A(a), .B(b),
      .GT_IN(gi), .EQ_IN(ei), .LT_IN(li),
      .BUSY(busy), .DONE(done), .GT(gt), .EQ(eq), .LT(lt), .CYCLES(cycles)
   );

   mod_serial_comp #(.N(1)) u_dut1 (
      .CLK(clk), .RST(rst), .START(start1), .A(a1), .B(b1),
      .GT_IN(gi1), .EQ_IN(ei1), .LT_IN(li1),
      .BUSY(busy1), .DONE(done1), .GT(gt1), .EQ(eq1), .LT(lt1), .CYCLES(cycles1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   casc;
      logic [2:0]   res;
      int           k;
   } vec_t;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: numeric compare; decision bit is the highest set bit of a^b.
   function automatic void ref_cmp(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                   input logic [2:0] casc,
                                   output logic [2:0] res, output int k);
      int x;
      x = int'(ra ^ rb);
      if (ra > rb)      res = 3'b100;
      else if (ra < rb) res = 3'b001;
      else              res = casc;
      if (x == 0) k = N;
      else        k = N + 1 - $clog2(x + 1);
   endfunction

   // Run one compare; optionally poke START with junk while busy.
   task automatic do_cmp(input logic [N-1:0] va, input logic [N-1:0] vb,
                         input logic [2:0] casc, input logic [2:0] res, input int k,
                         input bit noisy, input string tag);
      int lat;
      @(negedge clk);
      start = 1'b1; a = va; b = vb; {gi, ei, li} = casc;
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); {gi, ei, li} = 3'($urandom);
      chk({tag, " busy_after_start"}, int'(busy), 1);
      chk({tag, " res_cleared"}, int'({gt, eq, lt, cycles}), 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (noisy && !done) begin
            start = 1'($urandom);
            a = N'($urandom); b = N'($urandom); {gi, ei, li} = 3'($urandom);
         end else begin
            start = 1'b0;
         end
      end while (!done && lat < int'(N) + 2);
      start = 1'b0;
      chk({tag, " done"}, int'(done), 1);
      chk({tag, " latency"}, lat, k);
      chk({tag, " gt_eq_lt"}, int'({gt, eq, lt}), int'(res));
      chk({tag, " cycles"}, int'(cycles), k);
      chk({tag, " busy_in_done"}, int'(busy), 0);
      @(negedge clk);
      chk({tag, " done_pulse_end"}, int'(done), 0);
      chk({tag, " result_hold"}, int'({gt, eq, lt, cycles}), int'({res, CW'(k)}));
   endtask

   vec_t vecs[$];

   initial begin
      logic [2:0] r;
      int k;
      int lat;
      int seen;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; {gi, ei, li} = 3'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; {gi1, ei1, li1} = 3'b0;

      vecs.push_back('{4'b1010, 4'b1001, 3'b010, 3'b100, 3});
      vecs.push_back('{4'b0111, 4'b1000, 3'b010, 3'b001, 1});
      vecs.push_back('{4'b0101, 4'b0101, 3'b010, 3'b010, 4});
      vecs.push_back('{4'b0101, 4'b0101, 3'b100, 3'b100, 4});
      vecs.push_back('{4'b0101, 4'b0101, 3'b001, 3'b001, 4});
      vecs.push_back('{4'b0101, 4'b0101, 3'b111, 3'b111, 4});
      vecs.push_back('{4'b0000, 4'b0001, 3'b100, 3'b001, 4});
      vecs.push_back('{4'b1100, 4'b1110, 3'b000, 3'b001, 3});
      vecs.push_back('{4'b1111, 4'b0000, 3'b001, 3'b100, 1});

      #12;
      chk("reset_outputs", int'({busy, done, gt, eq, lt, cycles}), 0);
      chk("reset_outputs_n1", int'({busy1, done1, gt1, eq1, lt1, cycles1}), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < vecs.size(); i++)
         do_cmp(vecs[i].a, vecs[i].b, vecs[i].casc, vecs[i].res, vecs[i].k, 1'b0,
                $sformatf("vec%0d", i));

      // START while busy is ignored.
      @(negedge clk);
      start = 1'b1; a = 4'b0001; b = 4'b0000; {gi, ei, li} = 3'b010;
      @(negedge clk);
      a = 4'b0000; b = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      lat = 1; seen = 0;
      while (!done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("busy_ign done", int'(done), 1);
      chk("busy_ign latency", lat, 4);
      chk("busy_ign gt_eq_lt", int'({gt, eq, lt}), 3'b100);
      chk("busy_ign cycles", int'(cycles), 4);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("busy_ign extra_done", seen, 0);

      // Reset while idle clears held results.
      chk("pre_rst_hold_gt", int'(gt), 1);
      rst = 1'b1;
      #1;
      chk("rst_idle_clear", int'({busy, done, gt, eq, lt, cycles}), 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-compare aborts it.
      @(negedge clk);
      start = 1'b1; a = 4'b0101; b = 4'b0101; {gi, ei, li} = 3'b010;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("abort outputs", int'({busy, done, gt, eq, lt, cycles}), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("abort no_done", seen, 0);
      do_cmp(4'b0110, 4'b0011, 3'b010, 3'b100, 2, 1'b0, "post_rst");

      // START held through the DONE cycle launches a second compare.
      @(negedge clk);
      start = 1'b1; a = 4'b1000; b = 4'b0000; {gi, ei, li} = 3'b010;
      @(negedge clk);
      a = 4'b0011; b = 4'b0010;
      @(negedge clk);
      chk("b2b done1", int'(done), 1);
      chk("b2b res1", int'({gt, eq, lt, cycles}), int'({3'b100, CW'(1)}));
      chk("b2b busy_in_done", int'(busy), 0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b accepted", int'({busy, done}), 2);
      chk("b2b cleared", int'({gt, eq, lt, cycles}), 0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 8);
      chk("b2b done2", int'(done), 1);
      chk("b2b latency2", lat, 4);
      chk("b2b res2", int'({gt, eq, lt, cycles}), int'({3'b100, CW'(4)}));

      // Randomized compares against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic [N-1:0] ra, rb;
         logic [2:0] rc;
         ra = N'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : N'($urandom);
         rc = 3'($urandom);
         ref_cmp(ra, rb, rc, r, k);
         do_cmp(ra, rb, rc, r, k, 1'b1, $sformatf("rnd%0d", i));
      end

      // N=1 instance: every compare decides at the single bit.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         logic [2:0] exp1;
         ab = 2'(i);
         @(negedge clk);
         start1 = 1'b1; a1 = ab[1]; b1 = ab[0]; {gi1, ei1, li1} = 3'b100;
         @(negedge clk);
         start1 = 1'b0;
         chk($sformatf("n1_%0d busy", i), int'(busy1), 1);
         @(negedge clk);
         if (ab[1] > ab[0])      exp1 = 3'b100;
         else if (ab[1] < ab[0]) exp1 = 3'b001;
         else                    exp1 = 3'b100;
         chk($sformatf("n1_%0d done", i), int'(done1), 1);
         chk($sformatf("n1_%0d res", i), int'({gt1, eq1, lt1}), int'(exp1));
         chk($sformatf("n1_%0d cycles", i), int'(cycles1), 1);
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
